// File: rtl/mem_access_ctrl_if.sv
// SRAM-like data bus between the M-stage access controller and data memory.
// The controller owns req/wr/size/addr/wdata; memory answers with addr_ok/data_ok/rdata.
interface mem_access_ctrl_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// M-stage data-memory access controller: one bus transaction per load/store,
// pipeline stall while outstanding, aligned/extended load data back to M.
module mem_access_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         memenM,
  input  logic         memWriteM,
  input  logic [1:0]   sizeM,
  input  logic         signedM,
  input  logic [31:0]  addrM,
  input  logic [31:0]  wdataM,
  input  logic         flushM,
  input  logic         stall_other,
  output logic         adelM,
  output logic         adesM,
  output logic         memstall,
  output logic [31:0]  rdataM,
  output logic         rdata_valid,
  mem_access_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic        misalign_s;
  logic        valid_acc_s;
  logic        accept_s;
  logic        wr_r;
  logic [1:0]  size_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        signed_r;
  logic        kill_r;
  logic [31:0] rdata_r;
  logic        rdata_valid_r;
  logic        data_req_r;

  function automatic logic [31:0] replicate_store(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'd0:    replicate_store = {4{d[7:0]}};
      2'd1:    replicate_store = {2{d[15:0]}};
      default: replicate_store = d;
    endcase
  endfunction

  function automatic logic [31:0] align_load(input logic [1:0] size, input logic [1:0] lo,
                                             input logic sgn, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{lo, 3'b000} +: 8];
    h = lo[1] ? d[31:16] : d[15:0];
    case (size)
      2'd0:    align_load = {{24{sgn & b[7]}}, b};
      2'd1:    align_load = {{16{sgn & h[15]}}, h};
      default: align_load = d;
    endcase
  endfunction

  // Alignment check; size 3 behaves as a word access
  always_comb begin
    misalign_s = 1'b0;
    case (sizeM)
      2'd0:    misalign_s = 1'b0;
      2'd1:    misalign_s = addrM[0];
      default: misalign_s = (addrM[1:0] != 2'b00);
    endcase
  end

  assign adelM       = memenM & misalign_s & ~memWriteM;
  assign adesM       = memenM & misalign_s & memWriteM;
  assign valid_acc_s = memenM & ~flushM & ~misalign_s;
  assign accept_s    = (state_r == ST_IDLE) & valid_acc_s;
  assign memstall    = accept_s | (state_r == ST_REQ) | (state_r == ST_WAIT);

  // Next-state logic; a flush arriving with data_ok still discards the result
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (valid_acc_s) next_state_s = ST_REQ;
        else             next_state_s = ST_IDLE;
      end
      ST_REQ: begin
        if (bus.data_addr_ok) next_state_s = ST_WAIT;
        else                  next_state_s = ST_REQ;
      end
      ST_WAIT: begin
        if (bus.data_data_ok) next_state_s = (kill_r | flushM) ? ST_IDLE : ST_DONE;
        else                  next_state_s = ST_WAIT;
      end
      ST_DONE: begin
        if (stall_other) next_state_s = ST_DONE;
        else             next_state_s = ST_IDLE;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= next_state_s;
  end

  // Request fields, kill flag and load result; bus fields hold while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_req_r    <= 1'b0;
      rdata_valid_r <= 1'b0;
      wr_r          <= 1'b0;
      size_r        <= 2'd0;
      addr_r        <= 32'd0;
      wdata_r       <= 32'd0;
      signed_r      <= 1'b0;
      kill_r        <= 1'b0;
      rdata_r       <= 32'd0;
    end else begin
      data_req_r    <= (next_state_s == ST_REQ);
      rdata_valid_r <= (next_state_s == ST_DONE) & ~wr_r;
      if (accept_s) begin
        wr_r     <= memWriteM;
        size_r   <= (sizeM == 2'd3) ? 2'd2 : sizeM;
        addr_r   <= addrM;
        wdata_r  <= replicate_store(sizeM, wdataM);
        signed_r <= signedM;
        kill_r   <= 1'b0;
      end else if (((state_r == ST_REQ) || (state_r == ST_WAIT)) && flushM) begin
        kill_r <= 1'b1;
      end
      if ((state_r == ST_WAIT) && bus.data_data_ok && !wr_r) begin
        rdata_r <= align_load(size_r, addr_r[1:0], signed_r, bus.data_rdata);
      end
    end
  end

  assign bus.data_req   = data_req_r;
  assign bus.data_wr    = wr_r;
  assign bus.data_size  = size_r;
  assign bus.data_addr  = addr_r;
  assign bus.data_wdata = wdata_r;
  assign rdataM         = rdata_r;
  assign rdata_valid    = rdata_valid_r;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

M-stage data-memory access controller: the consumer of the pipelined memory control bits `memenM`/`memWriteM` that the main decoder produces. It turns one M-stage load/store into a single SRAM-like data-bus transaction (req/addr_ok/data_ok), stalls the pipeline while the transaction is outstanding, and returns load data aligned and extended. Misaligned accesses are flagged and never issued.

## Interface
Parameters:
- none; widths fixed at 32-bit address/data.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `memenM`  in  1  M-stage instruction is a load/store.
- `memWriteM`  in  1  1 = store, 0 = load.
- `sizeM`  in  2  0 byte, 1 half, 2 word; 3 is treated as word.
- `signedM`  in  1  load sign-extends (lb/lh); ignored for stores and words.
- `addrM`  in  32  effective address.
- `wdataM`  in  32  store data, right-justified.
- `flushM`  in  1  M-stage instruction is being killed (exception).
- `stall_other`  in  1  another unit is holding the M stage.
- `adelM`  out  1  load address error (comb.).
- `adesM`  out  1  store address error (comb.).
- `memstall`  out  1  hold pipeline stages F..M.
- `rdataM`  out  32  aligned/extended load result.
- `rdata_valid`  out  1  `rdataM` valid.
- `data_req`  out  1  bus request.
- `data_wr`  out  1  bus write.
- `data_size`  out  2  bus size (0/1/2).
- `data_addr`  out  32  bus address, byte-exact.
- `data_wdata`  out  32  lane-replicated store data.
- `data_addr_ok`  in  1  request accepted.
- `data_data_ok`  in  1  read data returned / write done.
- `data_rdata`  in  32  bus read data.

## Operation
- Misalignment: half with `addrM[0]`=1, word with `addrM[1:0]`!=0. `adelM`/`adesM` = `memenM` & misaligned & load/store; such accesses never leave IDLE.
- `valid_acc` = `memenM` & ~`flushM` & ~misaligned.
- Store data: byte -> {4{wdataM[7:0]}}, half -> {2{wdataM[15:0]}}, word unchanged.
- Load data: byte selects lane `addr[1:0]`, half selects lane `addr[1]`; zero- or sign-extend per `signedM`.
- States: IDLE, REQ, WAIT, DONE. Registers: state, req fields, `kill`, rdata.
- IDLE: if `valid_acc`, capture wr/size/addr/wdata/signed, clear `kill`, -> REQ.
- REQ: `data_req`=1 from captured fields; held until `data_addr_ok`, then -> WAIT. Request is never withdrawn.
- WAIT: on `data_data_ok`, capture aligned load data, -> DONE, or -> IDLE if `kill` set.
- DONE: `rdata_valid`=1 (loads only); stays while `stall_other`=1, -> IDLE when `stall_other`=0.
- `flushM` in REQ/WAIT sets `kill`: transaction completes on the bus, result discarded, no `rdata_valid`.
- `memstall` = (IDLE & `valid_acc`) | REQ | WAIT. Low in DONE.
- Bus data outputs hold their last value when `data_req`=0.

## Timing
- Reset: state IDLE, `kill`=0, `data_req`=0, `data_wr`=0, `data_size`=0, `data_addr`=0, `data_wdata`=0, `rdataM`=0, `rdata_valid`=0, `memstall`=0.
- Request outputs are registered. `memstall` and `adel`/`ades` are combinational.
- Minimum latency, with `addr_ok` in the first REQ cycle and `data_ok` the next cycle:
  - cycle 0 IDLE (accept, `memstall`=1);
  - cycle 1 REQ;
  - cycle 2 WAIT with `data_ok`;
  - cycle 3 DONE (`memstall`=0, data valid). The M stage advances at the end of cycle 3.
- `addr_ok` and `data_ok` arriving in the same cycle while in REQ: the `data_ok` is ignored. The slave must not return data before accepting the address.
- The instruction entering M after DONE is evaluated in the IDLE cycle that follows, so there are no back-to-back requests without one IDLE cycle.
- Async reset mid-transaction returns to IDLE immediately. The bus side is reset by the same `rst`.

## Test plan
- lw `addrM`=0x100, `addr_ok` 1 cycle and `data_ok` 1 cycle later, `data_rdata`=0xDEADBEEF -> `data_req` high for exactly 1 cycle, `data_size`=2, `rdataM`=0xDEADBEEF, `memstall` high for 3 cycles.
- lb `addrM`=0x103, `signedM`=1, `data_rdata`=0x80112233 -> `rdataM`=0xFFFFFF80. Same access with lbu -> 0x00000080. lh at 0x102 signed -> 0xFFFF8011.
- sb `addrM`=0x101, `wdataM`=0x000000AB -> `data_wr`=1, `data_addr`=0x101, `data_size`=0, `data_wdata`=0xABABABAB, `rdata_valid` never asserted.
- lw `addrM`=0x102 -> `adelM`=1, `data_req` never asserted, `memstall`=0. sh at 0x103 -> `adesM`=1.
- `addr_ok` delayed 4 cycles -> `data_req` and fields stable for all 5 cycles. `flushM` pulsed in WAIT -> transaction completes, FSM returns to IDLE, no `rdata_valid`.
- `stall_other`=1 for 2 cycles in DONE -> `rdataM` held for 3 cycles, no new `data_req` until `stall_other` falls.
